iob_native_bus_split: RTL and testbench
=======================================

# iob_native_bus_split

Sequential bridge between a PicoRV32-style native memory port (valid/instr/addr/wdata/wstrb → rdata/ready) and multiple IOb buses. It replaces the fixed two-way instruction/data split with one instruction port plus N_DBUS address-decoded data ports. It registers each request, runs the IOb ready/rvalid handshake, and returns a registered one-cycle native ready. It sits between the CPU core and the system interconnect.

## Interface
- ADDR_W, 32, native and IOb address width
- DATA_W, 32, data width; strobe width is DATA_W/8
- N_DBUS, 2, number of data ports (≥1)
- SEL_W, 1, data port index width, taken from addr[ADDR_W-1 -: SEL_W]; must satisfy 2^SEL_W ≥ N_DBUS
- TIMEOUT_W, 8, width of the timeout counter; used only with the timeout feature
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- cke_i  in  1  clock enable; when low, all state holds
- nat_valid_i  in  1  native request valid
- nat_instr_i  in  1  request is an instruction fetch
- nat_addr_i  in  ADDR_W  request address
- nat_wdata_i  in  DATA_W  write data
- nat_wstrb_i  in  DATA_W/8  byte strobes; 0 means read
- nat_rdata_o  out  DATA_W  registered read data
- nat_ready_o  out  1  one-cycle completion pulse
- ibus_valid_o / ibus_addr_o / ibus_ready_i / ibus_rvalid_i / ibus_rdata_i  instruction IOb port; reads only, no wdata/wstrb
- dbus_valid_o  out  N_DBUS  per-port request valid
- dbus_addr_o  out  N_DBUS*ADDR_W  per-port address (flat)
- dbus_wdata_o  out  N_DBUS*DATA_W  per-port write data (flat)
- dbus_wstrb_o  out  N_DBUS*DATA_W/8  per-port strobes (flat)
- dbus_ready_i  in  N_DBUS  per-port ready
- dbus_rvalid_i  in  N_DBUS  per-port rvalid
- dbus_rdata_i  in  N_DBUS*DATA_W  per-port read data (flat)
- error_o  out  1  sticky error flag

## Operation
- FSM states:
  - IDLE: accept nat_valid_i; latch addr, wdata, wstrb, instr and target. Target is ibus if instr=1, otherwise dbus[sel].
  - REQ: assert valid on the target only; on target ready, go to DONE if write, WAIT_R if read.
  - WAIT_R: on target rvalid, latch rdata and go to DONE.
  - DONE: nat_ready_o=1 for exactly one cycle, then IDLE.
- Data decode: sel ≥ N_DBUS is a decode error. IDLE goes straight to DONE with no bus access, nat_rdata_o=0, and error_o set.
- Exactly one port asserts valid, and only in REQ. Address, wdata and wstrb come from latched registers and stay stable while valid is high.
- Reads return target rdata captured on rvalid. Writes return nat_rdata_o unchanged.
- rvalid/ready on non-target ports, or while in IDLE or DONE, is ignored.
- In IDLE the FSM accepts a new request in the cycle right after DONE, even if nat_valid_i stayed high.
- Reset: state goes to IDLE and any in-flight transaction is dropped. Any late rvalid is ignored.
- cke_i low freezes the FSM, registers and timer. Outputs hold their values.

## Timing
- Reset values: every output is 0 (all valids, nat_ready_o, nat_rdata_o, error_o, addresses, wdata, wstrb).
- Request seen in IDLE at cycle 0 → target valid high from cycle 1.
- Write with ready at cycle 1 → nat_ready_o at cycle 2.
- Read with ready at cycle 1 and rvalid at cycle 2 → nat_ready_o and rdata at cycle 3.
- Each wait cycle on ready or rvalid adds one cycle.
- Decode error: nat_ready_o at cycle 1.

## Configuration
- IOB_NATIVE_SPLIT_TIMEOUT_EN, defined:
  - The counter clears on IDLE→REQ and increments each cycle in REQ or WAIT_R.
  - When it reaches 2^TIMEOUT_W−1 without the handshake, the FSM goes to DONE, drops target valid, returns rdata 0 and sets error_o.
- IOB_NATIVE_SPLIT_TIMEOUT_EN, undefined: the block waits indefinitely, the timer is absent, and error_o reflects decode errors only.

## Structure
- Package iob_native_split_pkg holds the state encoding (IDLE, REQ, WAIT_R, DONE) and the ERR_RDATA constant (0).
- One sub-module, iob_native_split_timer: clear/enable inputs and an expired output. It is instantiated only when IOB_NATIVE_SPLIT_TIMEOUT_EN is defined.

## Test plan
- Instruction fetch addr 0x100, ibus ready at cycle 1, rvalid with 0x00000013 at cycle 2 → nat_ready_o at cycle 3, nat_rdata_o=0x00000013, no dbus valid.
- Data write addr 0x8000_0010, wdata 0xCAFEF00D, wstrb 0xF → only dbus[1] valid, with those values. Ready at cycle 1 → nat_ready_o at cycle 2.
- Read with ready delayed 3 cycles and rvalid delayed 2 more → valid held stable for 4 cycles, nat_ready_o exactly once.
- N_DBUS=3, SEL_W=2, read with sel=3 → no valid on any port, nat_ready_o at cycle 1, rdata 0, error_o=1 until reset.
- rst_i asserted in WAIT_R, then rvalid arrives → all outputs 0, no nat_ready_o, next request served normally.
- With IOB_NATIVE_SPLIT_TIMEOUT_EN and TIMEOUT_W=4, target never ready → nat_ready_o after 15 wait cycles, error_o=1.

Source files
------------

// File: rtl/iob_native_split_pkg.sv
// Shared types and constants for the native-to-IOb bus splitter.
// State encoding is shared with the debug state output of iob_native_bus_split.
package iob_native_split_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Read data returned on a decode error or a timeout.
  localparam int ERR_RDATA = 0;

endpackage

// File: rtl/iob_native_split_timer.sv
// Saturating transaction timer for iob_native_bus_split.
// expired_o rises once the count reaches all-ones.
module iob_native_split_timer #(
  parameter int TIMEOUT_W = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic cke_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [TIMEOUT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (cke_i) begin
      if (clr_i) begin
        cnt_q <= '0;
      end else if (en_i && !expired_o) begin
        cnt_q <= cnt_q + TIMEOUT_W'(1);
      end
    end
  end

  assign expired_o = &cnt_q;

endmodule

// File: rtl/iob_native_bus_split.sv
// Native (PicoRV32-style) port to one instruction IOb port plus N_DBUS address-decoded data ports.
// Define IOB_NATIVE_SPLIT_TIMEOUT_EN to abort transactions that never complete their handshake.
module iob_native_bus_split #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int N_DBUS    = 2,
  parameter int SEL_W     = 1,
  parameter int TIMEOUT_W = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           cke_i,
  input  logic                           nat_valid_i,
  input  logic                           nat_instr_i,
  input  logic [ADDR_W-1:0]              nat_addr_i,
  input  logic [DATA_W-1:0]              nat_wdata_i,
  input  logic [DATA_W/8-1:0]            nat_wstrb_i,
  output logic [DATA_W-1:0]              nat_rdata_o,
  output logic                           nat_ready_o,
  output logic                           ibus_valid_o,
  output logic [ADDR_W-1:0]              ibus_addr_o,
  input  logic                           ibus_ready_i,
  input  logic                           ibus_rvalid_i,
  input  logic [DATA_W-1:0]              ibus_rdata_i,
  output logic [N_DBUS-1:0]              dbus_valid_o,
  output logic [N_DBUS*ADDR_W-1:0]       dbus_addr_o,
  output logic [N_DBUS*DATA_W-1:0]       dbus_wdata_o,
  output logic [N_DBUS*(DATA_W/8)-1:0]   dbus_wstrb_o,
  input  logic [N_DBUS-1:0]              dbus_ready_i,
  input  logic [N_DBUS-1:0]              dbus_rvalid_i,
  input  logic [N_DBUS*DATA_W-1:0]       dbus_rdata_i,
  output logic                           error_o,
  output logic [1:0]                     dbg_state_o
);

  import iob_native_split_pkg::*;

  localparam int STRB_W = DATA_W / 8;

  // Handshake: a target's valid rises the cycle after the native request is
  // accepted and falls the cycle after its ready is sampled high; ready is only
  // looked at in REQ and rvalid only in WAIT_R, and only on the latched target.

  state_t                state_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [STRB_W-1:0]     wstrb_q;
  logic                  tgt_ibus_q;
  logic [SEL_W-1:0]      tgt_sel_q;
  logic [DATA_W-1:0]     rdata_q;
  logic                  nat_ready_q;
  logic                  error_q;
  logic                  ibus_valid_q;
  logic [N_DBUS-1:0]     dbus_valid_q;

  logic [SEL_W-1:0]      sel_in;
  logic                  dec_err;
  logic [N_DBUS-1:0]     sel_hot;
  logic                  tgt_ready;
  logic                  tgt_rvalid;
  logic [DATA_W-1:0]     tgt_rdata;
  logic                  tgt_write;
  logic                  timeout;

  assign sel_in    = nat_addr_i[ADDR_W-1 -: SEL_W];
  assign dec_err   = int'(sel_in) >= N_DBUS;
  assign tgt_write = !tgt_ibus_q && (wstrb_q != '0);

  always_comb begin
    sel_hot = '0;
    for (int i = 0; i < N_DBUS; i++) begin
      if (int'(sel_in) == i) sel_hot[i] = 1'b1;
    end
  end

  // Only the latched target's handshake signals reach the FSM.
  always_comb begin
    tgt_ready  = 1'b0;
    tgt_rvalid = 1'b0;
    tgt_rdata  = '0;
    if (tgt_ibus_q) begin
      tgt_ready  = ibus_ready_i;
      tgt_rvalid = ibus_rvalid_i;
      tgt_rdata  = ibus_rdata_i;
    end else begin
      for (int i = 0; i < N_DBUS; i++) begin
        if (int'(tgt_sel_q) == i) begin
          tgt_ready  = dbus_ready_i[i];
          tgt_rvalid = dbus_rvalid_i[i];
          tgt_rdata  = dbus_rdata_i[i*DATA_W +: DATA_W];
        end
      end
    end
  end

`ifdef IOB_NATIVE_SPLIT_TIMEOUT_EN
  iob_native_split_timer #(
    .TIMEOUT_W (TIMEOUT_W)
  ) u_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .cke_i     (cke_i),
    .clr_i     ((state_q == IDLE) && nat_valid_i),
    .en_i      ((state_q == REQ) || (state_q == WAIT_R)),
    .expired_o (timeout)
  );
`else
  logic [TIMEOUT_W-1:0] unused_timer_cnt;
  assign unused_timer_cnt = '0;
  assign timeout          = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      tgt_ibus_q   <= 1'b0;
      tgt_sel_q    <= '0;
      rdata_q      <= '0;
      nat_ready_q  <= 1'b0;
      error_q      <= 1'b0;
      ibus_valid_q <= 1'b0;
      dbus_valid_q <= '0;
    end else if (cke_i) begin
      nat_ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (nat_valid_i) begin
            addr_q     <= nat_addr_i;
            wdata_q    <= nat_wdata_i;
            wstrb_q    <= nat_wstrb_i;
            tgt_ibus_q <= nat_instr_i;
            tgt_sel_q  <= sel_in;
            if (!nat_instr_i && dec_err) begin
              // Unmapped data port: complete immediately without touching any bus.
              state_q     <= DONE;
              nat_ready_q <= 1'b1;
              rdata_q     <= DATA_W'(ERR_RDATA);
              error_q     <= 1'b1;
            end else begin
              state_q      <= REQ;
              ibus_valid_q <= nat_instr_i;
              dbus_valid_q <= nat_instr_i ? '0 : sel_hot;
            end
          end
        end
        REQ: begin
          if (tgt_ready) begin
            ibus_valid_q <= 1'b0;
            dbus_valid_q <= '0;
            if (tgt_write) begin
              state_q     <= DONE;
              nat_ready_q <= 1'b1;
            end else begin
              state_q <= WAIT_R;
            end
          end else if (timeout) begin
            ibus_valid_q <= 1'b0;
            dbus_valid_q <= '0;
            state_q      <= DONE;
            nat_ready_q  <= 1'b1;
            rdata_q      <= DATA_W'(ERR_RDATA);
            error_q      <= 1'b1;
          end
        end
        WAIT_R: begin
          if (tgt_rvalid) begin
            rdata_q     <= tgt_rdata;
            state_q     <= DONE;
            nat_ready_q <= 1'b1;
          end else if (timeout) begin
            state_q     <= DONE;
            nat_ready_q <= 1'b1;
            rdata_q     <= DATA_W'(ERR_RDATA);
            error_q     <= 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign nat_rdata_o  = rdata_q;
  assign nat_ready_o  = nat_ready_q;
  assign error_o      = error_q;
  assign ibus_valid_o = ibus_valid_q;
  assign ibus_addr_o  = addr_q;
  assign dbus_valid_o = dbus_valid_q;
  assign dbus_addr_o  = {N_DBUS{addr_q}};
  assign dbus_wdata_o = {N_DBUS{wdata_q}};
  assign dbus_wstrb_o = {N_DBUS{wstrb_q}};
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_iob_native_bus_split.sv
// Directed bench for iob_native_bus_split: default 2-port instance (a) and a 3-port instance (b).
// Inputs change and outputs are sampled 2 time units after each rising edge.
module tb_iob_native_bus_split;

  logic clk = 1'b0;
  logic rst, cke;
  int checks = 0;
  int failures = 0;

  // Instance a: N_DBUS=2, SEL_W=1
  logic        a_nat_valid, a_nat_instr, a_nat_ready, a_error;
  logic [31:0] a_nat_addr, a_nat_wdata, a_nat_rdata;
  logic [3:0]  a_nat_wstrb;
  logic        a_ibus_valid, a_ibus_ready, a_ibus_rvalid;
  logic [31:0] a_ibus_addr, a_ibus_rdata;
  logic [1:0]  a_dbus_valid, a_dbus_ready, a_dbus_rvalid, a_state;
  logic [63:0] a_dbus_addr, a_dbus_wdata, a_dbus_rdata;
  logic [7:0]  a_dbus_wstrb;

  // Instance b: N_DBUS=3, SEL_W=2
  logic        b_nat_valid, b_nat_instr, b_nat_ready, b_error;
  logic [31:0] b_nat_addr, b_nat_wdata, b_nat_rdata;
  logic [3:0]  b_nat_wstrb;
  logic        b_ibus_valid, b_ibus_ready, b_ibus_rvalid;
  logic [31:0] b_ibus_addr, b_ibus_rdata;
  logic [2:0]  b_dbus_valid, b_dbus_ready, b_dbus_rvalid;
  logic [1:0]  b_state;
  logic [95:0] b_dbus_addr, b_dbus_wdata, b_dbus_rdata;
  logic [11:0] b_dbus_wstrb;

  int rd_pulses;
  int to_seen;

  always #5 clk = ~clk;

  iob_native_bus_split #(.TIMEOUT_W(4)) dut_a (
    .clk_i(clk), .rst_i(rst), .cke_i(cke),
    .nat_valid_i(a_nat_valid), .nat_instr_i(a_nat_instr), .nat_addr_i(a_nat_addr),
    .nat_wdata_i(a_nat_wdata), .nat_wstrb_i(a_nat_wstrb),
    .nat_rdata_o(a_nat_rdata), .nat_ready_o(a_nat_ready),
    .ibus_valid_o(a_ibus_valid), .ibus_addr_o(a_ibus_addr), .ibus_ready_i(a_ibus_ready),
    .ibus_rvalid_i(a_ibus_rvalid), .ibus_rdata_i(a_ibus_rdata),
    .dbus_valid_o(a_dbus_valid), .dbus_addr_o(a_dbus_addr), .dbus_wdata_o(a_dbus_wdata),
    .dbus_wstrb_o(a_dbus_wstrb), .dbus_ready_i(a_dbus_ready), .dbus_rvalid_i(a_dbus_rvalid),
    .dbus_rdata_i(a_dbus_rdata), .error_o(a_error), .dbg_state_o(a_state)
  );

  iob_native_bus_split #(.N_DBUS(3), .SEL_W(2)) dut_b (
    .clk_i(clk), .rst_i(rst), .cke_i(cke),
    .nat_valid_i(b_nat_valid), .nat_instr_i(b_nat_instr), .nat_addr_i(b_nat_addr),
    .nat_wdata_i(b_nat_wdata), .nat_wstrb_i(b_nat_wstrb),
    .nat_rdata_o(b_nat_rdata), .nat_ready_o(b_nat_ready),
    .ibus_valid_o(b_ibus_valid), .ibus_addr_o(b_ibus_addr), .ibus_ready_i(b_ibus_ready),
    .ibus_rvalid_i(b_ibus_rvalid), .ibus_rdata_i(b_ibus_rdata),
    .dbus_valid_o(b_dbus_valid), .dbus_addr_o(b_dbus_addr), .dbus_wdata_o(b_dbus_wdata),
    .dbus_wstrb_o(b_dbus_wstrb), .dbus_ready_i(b_dbus_ready), .dbus_rvalid_i(b_dbus_rvalid),
    .dbus_rdata_i(b_dbus_rdata), .error_o(b_error), .dbg_state_o(b_state)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; cke = 1'b1;
    a_nat_valid = 0; a_nat_instr = 0; a_nat_addr = 0; a_nat_wdata = 0; a_nat_wstrb = 0;
    a_ibus_ready = 0; a_ibus_rvalid = 0; a_ibus_rdata = 0;
    a_dbus_ready = 0; a_dbus_rvalid = 0; a_dbus_rdata = 0;
    b_nat_valid = 0; b_nat_instr = 0; b_nat_addr = 0; b_nat_wdata = 0; b_nat_wstrb = 0;
    b_ibus_ready = 0; b_ibus_rvalid = 0; b_ibus_rdata = 0;
    b_dbus_ready = 0; b_dbus_rvalid = 0; b_dbus_rdata = 0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset values
    chk("rst_nat_ready", a_nat_ready, 0);
    chk("rst_nat_rdata", a_nat_rdata, 0);
    chk("rst_error", a_error, 0);
    chk("rst_ibus_valid", a_ibus_valid, 0);
    chk("rst_ibus_addr", a_ibus_addr, 0);
    chk("rst_dbus_valid", a_dbus_valid, 0);
    chk("rst_dbus_addr", a_dbus_addr, 0);
    chk("rst_dbus_wdata", a_dbus_wdata, 0);
    chk("rst_dbus_wstrb", a_dbus_wstrb, 0);
    chk("rst_state", a_state, 0);
    chk("rst_b_dbus_valid", b_dbus_valid, 0);

    // Instruction fetch: ready at cycle 1, rvalid at cycle 2, native ready at cycle 3
    a_nat_valid = 1; a_nat_instr = 1; a_nat_addr = 32'h0000_0100; a_nat_wstrb = 0;
    tick();
    chk("if_ibus_valid", a_ibus_valid, 1);
    chk("if_ibus_addr", a_ibus_addr, 32'h100);
    chk("if_no_dbus", a_dbus_valid, 0);
    chk("if_no_ready_c1", a_nat_ready, 0);
    a_nat_valid = 0; a_ibus_ready = 1;
    tick();
    chk("if_valid_drop", a_ibus_valid, 0);
    chk("if_no_ready_c2", a_nat_ready, 0);
    a_ibus_ready = 0; a_ibus_rvalid = 1; a_ibus_rdata = 32'h0000_0013;
    tick();
    chk("if_ready_c3", a_nat_ready, 1);
    chk("if_rdata", a_nat_rdata, 32'h13);
    chk("if_no_dbus_c3", a_dbus_valid, 0);
    a_ibus_rvalid = 0; a_ibus_rdata = 0;
    tick();
    chk("if_ready_pulse", a_nat_ready, 0);
    chk("if_idle", a_state, 0);

    // Data write to port 1, native valid left high to issue a second request
    a_nat_valid = 1; a_nat_instr = 0; a_nat_addr = 32'h8000_0010;
    a_nat_wdata = 32'hCAFE_F00D; a_nat_wstrb = 4'hF;
    tick();
    chk("wr_dbus_valid", a_dbus_valid, 2'b10);
    chk("wr_ibus_valid", a_ibus_valid, 0);
    chk("wr_addr", a_dbus_addr[63:32], 32'h8000_0010);
    chk("wr_wdata", a_dbus_wdata[63:32], 32'hCAFE_F00D);
    chk("wr_wstrb", a_dbus_wstrb[7:4], 4'hF);
    a_dbus_ready = 2'b10;
    tick();
    chk("wr_ready_c2", a_nat_ready, 1);
    chk("wr_rdata_kept", a_nat_rdata, 32'h13);
    chk("wr_valid_drop", a_dbus_valid, 0);
    a_dbus_ready = 0;
    a_nat_addr = 32'h0000_0020; a_nat_wdata = 32'h1234_5678; a_nat_wstrb = 4'b0011;
    tick();
    chk("b2b_gap_valid", a_dbus_valid, 0);
    chk("b2b_gap_ready", a_nat_ready, 0);
    chk("b2b_gap_state", a_state, 0);
    tick();
    chk("b2b_valid", a_dbus_valid, 2'b01);
    chk("b2b_addr", a_dbus_addr[31:0], 32'h20);
    chk("b2b_wdata", a_dbus_wdata[31:0], 32'h1234_5678);
    chk("b2b_wstrb", a_dbus_wstrb[3:0], 4'b0011);
    a_nat_valid = 0; a_dbus_ready = 2'b01;
    tick();
    chk("b2b_ready", a_nat_ready, 1);
    chk("b2b_rdata_kept", a_nat_rdata, 32'h13);
    a_dbus_ready = 0; a_nat_wstrb = 0; a_nat_wdata = 0;
    tick();
    chk("b2b_ready_pulse", a_nat_ready, 0);

    // Port 0 read: ready in cycle 4, rvalid in cycle 7, stray handshakes on other ports
    a_nat_valid = 1; a_nat_instr = 0; a_nat_addr = 32'h0000_0044; a_nat_wstrb = 0;
    rd_pulses = 0;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c == 1) a_nat_valid = 0;
      rd_pulses += int'(a_nat_ready);
      if (c <= 4) begin
        chk("rd_valid_held", a_dbus_valid, 2'b01);
        chk("rd_addr_stable", a_dbus_addr[31:0], 32'h44);
      end else begin
        chk("rd_valid_low", a_dbus_valid, 0);
      end
      chk("rd_ready_at_c8", a_nat_ready, (c == 8));
      if (c == 8) chk("rd_rdata", a_nat_rdata, 32'hA5A5_0044);
      a_dbus_ready  = (c == 4) ? 2'b01 : (c == 2) ? 2'b10 : 2'b00;
      a_dbus_rvalid = (c == 7) ? 2'b01 : (c == 2 || c == 5) ? 2'b10 : 2'b00;
      a_ibus_rvalid = (c == 5);
      a_ibus_rdata  = (c == 5) ? 32'h7777_7777 : 32'h0;
      a_dbus_rdata  = (c == 7) ? {32'hDEAD_BEEF, 32'hA5A5_0044} : {32'h5555_5555, 32'h6666_6666};
    end
    chk("rd_single_ready", rd_pulses, 1);
    a_dbus_rdata = 0;

    // Clock enable low freezes the FSM in REQ and in WAIT_R
    a_nat_valid = 1; a_nat_instr = 1; a_nat_addr = 32'h0000_0300;
    tick();
    chk("cke_valid", a_ibus_valid, 1);
    a_nat_valid = 0; a_ibus_ready = 1; cke = 0;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("cke_hold_valid", a_ibus_valid, 1);
      chk("cke_hold_state", a_state, 1);
    end
    cke = 1;
    tick();
    chk("cke_wait_r_valid", a_ibus_valid, 0);
    chk("cke_wait_r_state", a_state, 2);
    a_ibus_ready = 0; a_ibus_rvalid = 1; a_ibus_rdata = 32'h0BAD_CAFE; cke = 0;
    tick();
    chk("cke_frozen_ready", a_nat_ready, 0);
    chk("cke_frozen_state", a_state, 2);
    cke = 1;
    tick();
    chk("cke_ready", a_nat_ready, 1);
    chk("cke_rdata", a_nat_rdata, 32'h0BAD_CAFE);
    a_ibus_rvalid = 0; a_ibus_rdata = 0;
    tick();

    // Reset while waiting for rvalid, then a late rvalid
    a_nat_valid = 1; a_nat_instr = 0; a_nat_addr = 32'h8000_0008; a_nat_wstrb = 0;
    tick();
    chk("mrst_pre_valid", a_dbus_valid, 2'b10);
    a_nat_valid = 0; a_dbus_ready = 2'b10;
    tick();
    chk("mrst_wait_r", a_state, 2);
    a_dbus_ready = 0; rst = 1;
    tick();
    chk("mrst_nat_ready", a_nat_ready, 0);
    chk("mrst_rdata", a_nat_rdata, 0);
    chk("mrst_error", a_error, 0);
    chk("mrst_dbus_valid", a_dbus_valid, 0);
    chk("mrst_ibus_valid", a_ibus_valid, 0);
    chk("mrst_dbus_addr", a_dbus_addr, 0);
    chk("mrst_ibus_addr", a_ibus_addr, 0);
    chk("mrst_state", a_state, 0);
    rst = 0; a_dbus_rvalid = 2'b10; a_dbus_rdata = {32'hFEED_FACE, 32'h0};
    tick();
    chk("late_rvalid_ready", a_nat_ready, 0);
    chk("late_rvalid_rdata", a_nat_rdata, 0);
    chk("late_rvalid_state", a_state, 0);
    a_dbus_rvalid = 0; a_dbus_rdata = 0;
    a_nat_valid = 1; a_nat_addr = 32'h0000_0004; a_nat_wdata = 32'h0000_00AA; a_nat_wstrb = 4'b0001;
    tick();
    chk("post_rst_valid", a_dbus_valid, 2'b01);
    chk("post_rst_wstrb", a_dbus_wstrb[3:0], 4'b0001);
    a_nat_valid = 0; a_dbus_ready = 2'b01;
    tick();
    chk("post_rst_ready", a_nat_ready, 1);
    a_dbus_ready = 0; a_nat_wstrb = 0; a_nat_wdata = 0;
    tick();

    // Target never ready: times out with TIMEOUT_W=4, otherwise waits indefinitely
    a_nat_valid = 1; a_nat_instr = 0; a_nat_addr = 32'h0000_0008; a_nat_wstrb = 0;
    to_seen = 0;
    for (int c = 1; c <= 24; c++) begin
      tick();
      if (c == 1) a_nat_valid = 0;
      if (a_nat_ready && to_seen == 0) to_seen = c;
    end
`ifdef IOB_NATIVE_SPLIT_TIMEOUT_EN
    chk("to_ready_cycle", to_seen, 17);
    chk("to_error", a_error, 1);
    chk("to_rdata", a_nat_rdata, 0);
    chk("to_valid_dropped", a_dbus_valid, 0);
`else
    chk("hang_no_ready", to_seen, 0);
    chk("hang_valid_held", a_dbus_valid, 2'b01);
    chk("hang_error", a_error, 0);
`endif
    rst = 1;
    tick();
    rst = 0;
    tick();

    // Instance b: read on port 2, then a decode error with sel=3
    b_nat_valid = 1; b_nat_instr = 0; b_nat_addr = 32'h8000_0004; b_nat_wstrb = 0;
    tick();
    chk("b_p2_valid", b_dbus_valid, 3'b100);
    chk("b_p2_addr", b_dbus_addr[95:64], 32'h8000_0004);
    b_nat_valid = 0; b_dbus_ready = 3'b100;
    tick();
    b_dbus_ready = 0; b_dbus_rvalid = 3'b100; b_dbus_rdata = {32'h1122_3344, 64'h0};
    tick();
    chk("b_p2_ready", b_nat_ready, 1);
    chk("b_p2_rdata", b_nat_rdata, 32'h1122_3344);
    b_dbus_rvalid = 0; b_dbus_rdata = 0;
    tick();
    b_nat_valid = 1; b_nat_addr = 32'hC000_0000;
    tick();
    chk("de_ready_c1", b_nat_ready, 1);
    chk("de_rdata", b_nat_rdata, 0);
    chk("de_error", b_error, 1);
    chk("de_no_dbus_valid", b_dbus_valid, 0);
    chk("de_no_ibus_valid", b_ibus_valid, 0);
    b_nat_valid = 0;
    repeat (5) tick();
    chk("de_error_sticky", b_error, 1);
    chk("de_no_valid_later", b_dbus_valid, 0);
    chk("de_ready_once", b_nat_ready, 0);
    rst = 1;
    tick();
    rst = 0;
    tick();
    chk("de_error_cleared", b_error, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
